// File: rtl/kmeans_pkg.sv
// Shared k-means constants, FSM state encoding and entry helpers.
// Entries are numbered cluster-major: entry e covers cluster e/2, axis e%2.
package kmeans_pkg;

    localparam int K  = 4;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int SW = DW + CW;

    localparam int IW = $clog2(K);
    localparam int NE = 2 * K;
    localparam int EW = $clog2(NE);

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef enum logic [2:0] {
        ACCUM = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        WRITE = 3'd3,
        CLEAR = 3'd4
    } state_t;

    function automatic logic [IW-1:0] entry_idx(input logic [EW-1:0] e);
        return e[EW-1:1];
    endfunction

    function automatic logic entry_axis(input logic [EW-1:0] e);
        return e[0];
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, SW cycles after start.
// done is high during the cycle whose closing edge retires the last bit.
module udiv_seq #(
    parameter int SW = 48,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] quotient,
    output logic [CW-1:0] remainder
);

    localparam int TW = $clog2(SW + 1);

    logic [TW-1:0] steps;
    logic [CW:0]   rem_q;
    logic [CW:0]   rem_sh;
    logic [CW:0]   rem_nx;
    logic [SW-1:0] quo_q;
    logic [CW-1:0] dvs_q;
    logic          q_bit;

    always_comb begin
        rem_sh = {rem_q[CW-1:0], quo_q[SW-1]};
        q_bit  = (rem_sh >= {1'b0, dvs_q});
        rem_nx = q_bit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            steps <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            steps <= TW'(SW);
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            busy  <= 1'b1;
        end else if (busy) begin
            rem_q <= rem_nx;
            quo_q <= {quo_q[SW-2:0], q_bit};
            steps <= steps - 1'b1;
            if (steps == TW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done      = busy && (steps == TW'(1)) && !start;
    assign quotient  = quo_q;
    assign remainder = rem_q[CW-1:0];

endmodule

// File: rtl/centroid_update.sv
// Centroid-update stage: accumulates assigned points per cluster, then on epoch_end
// divides each (cluster, axis) sum by its count and writes the new centroid.
//
// state | meaning
// ACCUM | accept points into per-cluster sums and counts
// LOAD  | select entry e; skip when its count is zero, else start the divider
// DIV   | wait for the divider to retire all quotient bits
// WRITE | emit one centroid write for entry e
// CLEAR | zero accumulators and overflow flag, pulse done
module centroid_update
    import kmeans_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          pt_valid,
    input  logic [DW-1:0] pt_x,
    input  logic [DW-1:0] pt_y,
    input  logic [IW-1:0] pt_idx,
    input  logic          epoch_end,
    output logic          busy,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic          wr_axis,
    output logic [DW-1:0] wr_data,
    output logic          done,
    output logic          cnt_ovf
);

    state_t state, state_nx;

    logic [SW-1:0] sum_x [K];
    logic [SW-1:0] sum_y [K];
    logic [CW-1:0] cnt   [K];

    logic [EW-1:0] ent;
    logic          last_ent;
    logic [CW-1:0] sel_cnt;
    logic [SW-1:0] sel_sum;

    logic          accum_en;
    logic          pt_drop;
    logic          div_start;
    logic          ent_adv;
    logic          clr_acc;
    logic          wr_fire;
    logic          done_fire;

    logic          div_busy;
    logic          div_done;
    logic [SW-1:0] quotient;
    logic [CW-1:0] div_rem;
    logic          div_unused;

    assign last_ent = (ent == EW'(NE - 1));
    assign sel_cnt  = cnt[entry_idx(ent)];
    assign sel_sum  = (entry_axis(ent) == AXIS_Y) ? sum_y[entry_idx(ent)]
                                                  : sum_x[entry_idx(ent)];

    udiv_seq #(
        .SW(SW),
        .CW(CW)
    ) u_div (
        .clk      (clk),
        .rst_b    (reset),
        .start    (div_start),
        .dividend (sel_sum),
        .divisor  (sel_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient),
        .remainder(div_rem)
    );

    // Mean of DW-bit values always fits DW bits, so the upper quotient bits stay zero.
    assign div_unused = ^{div_busy, div_rem, quotient[SW-1:DW]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (epoch_end) state_nx = LOAD;
            LOAD: begin
                if (sel_cnt != '0) begin
                    state_nx = DIV;
                end else if (last_ent) begin
                    state_nx = CLEAR;
                end
            end
            DIV:   if (div_done) state_nx = WRITE;
            WRITE: state_nx = last_ent ? CLEAR : LOAD;
            CLEAR: state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        accum_en  = 1'b0;
        div_start = 1'b0;
        ent_adv   = 1'b0;
        clr_acc   = 1'b0;
        wr_fire   = 1'b0;
        done_fire = 1'b0;
        case (state)
            ACCUM: accum_en = pt_valid;
            LOAD: begin
                if (sel_cnt != '0) begin
                    div_start = 1'b1;
                end else begin
                    ent_adv = 1'b1;
                end
            end
            WRITE: begin
                wr_fire = 1'b1;
                ent_adv = 1'b1;
            end
            CLEAR: begin
                clr_acc   = 1'b1;
                done_fire = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent <= '0;
        end else if (state == ACCUM) begin
            ent <= '0;
        end else if (ent_adv) begin
            ent <= ent + 1'b1;
        end
    end

    // A saturated count drops the point entirely so sum/count stays a true mean.
    assign pt_drop = accum_en && (cnt[pt_idx] == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
            cnt_ovf <= 1'b0;
        end else if (clr_acc) begin
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
            cnt_ovf <= 1'b0;
        end else if (accum_en) begin
            if (pt_drop) begin
                cnt_ovf <= 1'b1;
            end else begin
                sum_x[pt_idx] <= sum_x[pt_idx] + SW'(pt_x);
                sum_y[pt_idx] <= sum_y[pt_idx] + SW'(pt_y);
                cnt[pt_idx]   <= cnt[pt_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_idx  <= '0;
            wr_axis <= 1'b0;
            wr_data <= '0;
        end else begin
            busy    <= (state != ACCUM);
            done    <= done_fire;
            wr_en   <= wr_fire;
            wr_idx  <= wr_fire ? entry_idx(ent) : '0;
            wr_axis <= wr_fire ? entry_axis(ent) : 1'b0;
            wr_data <= wr_fire ? quotient[DW-1:0] : '0;
        end
    end

endmodule
